div_seq_row_ctrl: RTL and testbench

- Sequential 16/8 restoring divider controller. It reuses a single 8-cell subtractor row for 8 cycles instead of the 64-cell combinational triangular array.
- Bit-accurate against the triangular-approximate array family: row i, column j uses the approximate cell when approx_en=1 and i+j < APPROX_DEPTH; otherwise it uses the exact cell.
- Sits between a requester and consumer using valid/ready handshakes; intended for the area-vs-MAE sweep alongside the array variants.

---
 rtl/div_seq_row_ctrl.sv | 163 ++++++++++++++++
 tb/tb_div_seq_row_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_row_ctrl.sv
// Sequential 16/8 restoring divider: one 8-cell subtractor row reused for 8 cycles,
// bit-accurate against the triangular-approximate array family.
module div_seq_row_ctrl #(
  parameter int unsigned APPROX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [15:0] n,
  input  logic [7:0] d,
  input  logic       approx_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] q,
  output logic [7:0] r,
  output logic       ovf,
  output logic       dbz,
  output logic       busy
);

  localparam int unsigned NW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] num_q, num_d;
  logic [DW-1:0] den_q, den_d;
  logic          apx_q, apx_d;
  logic [DW-1:0] p_q, p_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          dbz_q, dbz_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic [DW-1:0] row_x;
  logic          row_top;
  logic [DW-1:0] row_diff;
  logic          row_bor;
  logic          row_qi;

  // One divider row: ripple-borrow subtract of d from the shifted partial remainder
  always_comb begin
    row_x    = '0;
    row_top  = 1'b0;
    row_diff = '0;
    row_bor  = 1'b0;
    if (cnt_q == CW'(7)) begin
      row_x   = num_q[14:7];
      row_top = num_q[15];
    end else begin
      row_x   = {p_q[6:0], num_q[4'(cnt_q)]};
      row_top = p_q[7];
    end
    for (int unsigned j = 0; j < DW; j++) begin
      if (apx_q && ((32'(cnt_q) + j) < APPROX_DEPTH)) begin
        row_diff[3'(j)] = (~row_x[3'(j)] & den_q[3'(j)] & ~row_bor)
                        | (row_x[3'(j)] & ~den_q[3'(j)]);
        row_bor         = (~row_x[3'(j)] & ~den_q[3'(j)] & row_bor)
                        | (~row_x[3'(j)] & den_q[3'(j)])
                        | (row_x[3'(j)] & den_q[3'(j)] & row_bor);
      end else begin
        row_diff[3'(j)] = row_x[3'(j)] ^ den_q[3'(j)] ^ row_bor;
        row_bor         = (~row_x[3'(j)] & den_q[3'(j)])
                        | (~(row_x[3'(j)] ^ den_q[3'(j)]) & row_bor);
      end
    end
    row_qi = row_top | ~row_bor;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    apx_d   = apx_q;
    p_d     = p_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          num_d   = n;
          den_d   = d;
          apx_d   = approx_en;
          ovf_d   = (n[15:8] >= d);
          dbz_d   = (d == '0);
          quo_d   = '0;
          cnt_d   = CW'(7);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        p_d        = row_qi ? row_diff : row_x;
        quo_d[cnt_q] = row_qi;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      num_q       <= '0;
      den_q       <= '0;
      apx_q       <= 1'b0;
      p_q         <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      den_q       <= den_d;
      apx_q       <= apx_d;
      p_q         <= p_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign q         = quo_q;
  assign r         = p_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_seq_row_ctrl.sv
// Directed and randomized bench for div_seq_row_ctrl against a row-by-row array model.
module tb_div_seq_row_ctrl;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] n;
  logic [7:0]  d;
  logic        approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        ovf;
  logic        dbz;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  int          lat;
  int unsigned acc_cyc, done_cyc, prev_done;
  logic [7:0]  res_q, res_r, mq, mr;
  logic        res_ovf, res_dbz;

  div_seq_row_ctrl #(.APPROX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .d(d), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .q(q), .r(r), .ovf(ovf), .dbz(dbz), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Array model: each row subtracts d from a 9-bit window, cell by cell, with
  // the approximate cell given by its truth table.
  function automatic void model(input logic [15:0] nn, input logic [7:0] dd, input bit ax,
                                output logic [7:0] oq, output logic [7:0] orr);
    logic [7:0] dtab;
    logic [7:0] btab;
    logic [8:0] w;
    logic [7:0] p;
    logic [7:0] diff8;
    int         xb, yb, bor, s, idx;
    logic       qi;
    dtab = 8'h34;
    btab = 8'h8E;
    p    = nn[15:8];
    oq   = '0;
    for (int i = 7; i >= 0; i--) begin
      w     = {p, nn[i]};
      bor   = 0;
      diff8 = '0;
      for (int j = 0; j < 8; j++) begin
        xb = int'(w[j]);
        yb = int'(dd[j]);
        if (ax && (i + j < DEPTH)) begin
          idx      = xb * 4 + yb * 2 + bor;
          diff8[j] = dtab[idx];
          bor      = int'(btab[idx]);
        end else begin
          s        = xb - yb - bor;
          diff8[j] = s[0];
          bor      = (s < 0) ? 1 : 0;
        end
      end
      qi    = w[8] | (bor == 0);
      oq[i] = qi;
      p     = qi ? diff8 : w[7:0];
    end
    orr = p;
  endfunction

  // Issue one request from a negedge in IDLE, wait for the result, then handshake.
  task automatic run_op(input logic [15:0] nn, input logic [7:0] dd, input bit ax, input bit tied);
    int k;
    n = nn;
    d = dd;
    approx_en = ax;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 32'(in_ready), 1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid  = 1'b0;
    n         = 16'($urandom);
    d         = 8'($urandom);
    approx_en = 1'($urandom);
    k = 1;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("out_valid_seen", 32'(out_valid), 1);
    lat      = k;
    done_cyc = cyc;
    res_q    = q;
    res_r    = r;
    res_ovf  = ovf;
    res_dbz  = dbz;
    if (!tied) out_ready = 1'b1;
    @(negedge clk);
    if (!tied) out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] nv;
    logic [7:0]  dv;
    int          k;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n = '0;
    d = '0;
    approx_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_r", 32'(r), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_dbz", 32'(dbz), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact division
    run_op(16'd100, 8'd7, 1'b0, 1'b0);
    chk("ex_lat", 32'(lat), 9);
    chk("ex_q", 32'(res_q), 14);
    chk("ex_r", 32'(res_r), 2);
    chk("ex_ovf", 32'(res_ovf), 0);
    chk("ex_dbz", 32'(res_dbz), 0);

    // Divide by zero
    run_op(16'h00FF, 8'd0, 1'b0, 1'b0);
    chk("dbz_q", 32'(res_q), 255);
    chk("dbz_r", 32'(res_r), 255);
    chk("dbz_flag", 32'(res_dbz), 1);
    chk("dbz_ovf", 32'(res_ovf), 1);

    // Backpressure with in_valid held high throughout
    chk("bp_idle", 32'(in_ready), 1);
    n = 16'd1000;
    d = 8'd10;
    approx_en = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_busy", 32'(busy), 1);
    k = 1;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_lat", 32'(k), 9);
    n = 16'd77;
    d = 8'd5;
    for (int c = 0; c < 6; c++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_q", 32'(q), 100);
      chk("bp_r", 32'(r), 0);
      chk("bp_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_release_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accept", 32'(busy), 1);
    chk("bp_second_in_ready", 32'(in_ready), 0);
    k = 1;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp2_lat", 32'(k), 9);
    chk("bp2_q", 32'(q), 15);
    chk("bp2_r", 32'(r), 2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during RUN cycle 4
    n = 16'd500;
    d = 8'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_q", 32'(q), 0);
    chk("mr_r", 32'(r), 0);
    chk("mr_ovf", 32'(ovf), 0);
    chk("mr_dbz", 32'(dbz), 0);
    chk("mr_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_post_ready", 32'(in_ready), 1);
    chk("mr_post_valid", 32'(out_valid), 0);
    run_op(16'd500, 8'd3, 1'b0, 1'b0);
    chk("mr_new_q", 32'(res_q), 166);
    chk("mr_new_r", 32'(res_r), 2);

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      dv = 8'($urandom_range(1, 255));
      nv = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom)};
      prev_done = done_cyc;
      run_op(nv, dv, 1'b0, 1'b1);
      chk("b2b_lat", 32'(lat), 9);
      chk("b2b_q", 32'(res_q), 32'(int'(nv) / int'(dv)));
      chk("b2b_r", 32'(res_r), 32'(int'(nv) % int'(dv)));
      if (b > 0) chk("b2b_gap", acc_cyc - prev_done, 1);
    end

    // Random sweep: approximate vs array model, then exact vs arithmetic
    for (int t = 0; t < 2000; t++) begin
      dv = 8'($urandom_range(1, 255));
      nv = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom)};
      model(nv, dv, 1'b1, mq, mr);
      run_op(nv, dv, 1'b1, 1'b1);
      chk("apx_q", 32'(res_q), 32'(mq));
      chk("apx_r", 32'(res_r), 32'(mr));
      run_op(nv, dv, 1'b0, 1'b1);
      chk("exs_q", 32'(res_q), 32'(int'(nv) / int'(dv)));
      chk("exs_r", 32'(res_r), 32'(int'(nv) % int'(dv)));
    end
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
